// File: rtl/fib_arbiter.sv
// fib_arbiter
//   Round-robin arbiter/sequencer that shares a single fib FSMD among N_REQ
//   requesters. One requester is granted at a time; its 5-bit index is sent
//   to fib with a one-cycle start pulse, the 20-bit result is captured on
//   done_tick and returned with a one-cycle resp_valid pulse.
//
//   Optional feature macro: FIB_ARB_CACHE_EN
//     When defined, a single-entry result cache (last index/result pair)
//     lets a repeated index be answered straight from IDLE without running
//     fib. When undefined, every request goes through ISSUE/WAIT.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   req            in   [N_REQ]   level request per requester
//   req_i          in   [5*N_REQ] index bus, requester k on [5k+4:5k]
//   grant          out  [N_REQ]   one-hot of the requester being serviced
//   resp_valid     out  [N_REQ]   one-hot one-cycle response pulse
//   resp_f         out  [20]      last result, held until next response
//   busy           out            high whenever not IDLE
//   fib_start      out            start pulse to fib
//   fib_i          out  [5]       registered index to fib
//   fib_ready      in             fib.ready
//   fib_done_tick  in             fib.done_tick
//   fib_f          in   [20]      fib.f
module fib_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [5*N_REQ-1:0] req_i,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [19:0]        resp_f,
  output logic               busy,
  output logic               fib_start,
  output logic [4:0]         fib_i,
  input  logic               fib_ready,
  input  logic               fib_done_tick,
  input  logic [19:0]        fib_f
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [IDW-1:0]   id_reg, id_next;
  logic [4:0]       idx_reg, idx_next;
  logic [19:0]      resp_f_reg, resp_f_next;

  logic [IDW-1:0]   winner;
  logic [4:0]       winner_idx;
  logic             any_req;

  // Per-requester index slices, candidate order for the circular search
  // (candidate 0 is ptr+1, the highest priority), and one-hot of id_reg.
  logic [4:0]       req_idx  [N_REQ];
  logic [IDW-1:0]   cand_id  [N_REQ];
  logic [N_REQ-1:0] cand_vld;
  logic [N_REQ-1:0] id_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_idx[gi]   = req_i[5*gi +: 5];
      assign cand_id[gi]   = IDW'((int'(ptr_reg) + gi + 1) % N_REQ);
      assign cand_vld[gi]  = req[cand_id[gi]];
      assign id_onehot[gi] = (id_reg == IDW'(gi));
    end
  endgenerate

  // Scan from the lowest-priority candidate upward so the last hit, i.e.
  // the candidate closest to ptr+1, is the one that sticks.
  always_comb begin
    winner = cand_id[0];
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_vld[k]) begin
        winner = cand_id[k];
      end
    end
  end

  assign any_req    = |req;
  assign winner_idx = req_idx[winner];

`ifdef FIB_ARB_CACHE_EN
  logic        cache_vld_reg;
  logic [4:0]  cache_idx_reg;
  logic [19:0] cache_f_reg;
  logic        cache_hit;
  logic [19:0] cache_f;

  // Refilled with every result that fib actually produces.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_vld_reg <= 1'b0;
      cache_idx_reg <= '0;
      cache_f_reg   <= '0;
    end else if (state_reg == ST_WAIT && fib_done_tick) begin
      cache_vld_reg <= 1'b1;
      cache_idx_reg <= idx_reg;
      cache_f_reg   <= fib_f;
    end
  end

  assign cache_hit = cache_vld_reg && (cache_idx_reg == winner_idx);
  assign cache_f   = cache_f_reg;
`else
  logic        cache_hit;
  logic [19:0] cache_f;

  assign cache_hit = 1'b0;
  assign cache_f   = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= IDW'(N_REQ - 1);
      id_reg     <= '0;
      idx_reg    <= '0;
      resp_f_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      id_reg     <= id_next;
      idx_reg    <= idx_next;
      resp_f_reg <= resp_f_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    id_next     = id_reg;
    idx_next    = idx_reg;
    resp_f_next = resp_f_reg;

    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          // A cache hit is answered without fib, so fib_ready is irrelevant.
          if (cache_hit) begin
            id_next     = winner;
            idx_next    = winner_idx;
            resp_f_next = cache_f;
            state_next  = ST_RESP;
          end else if (fib_ready) begin
            id_next    = winner;
            idx_next   = winner_idx;
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (fib_done_tick) begin
          resp_f_next = fib_f;
          state_next  = ST_RESP;
        end
      end
      ST_RESP: begin
        ptr_next   = id_reg;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decode the asynchronously reset state, so they clear the
  // moment rst rises.
  assign busy       = (state_reg != ST_IDLE);
  assign fib_start  = (state_reg == ST_ISSUE);
  assign fib_i      = idx_reg;
  assign resp_f     = resp_f_reg;
  assign grant      = busy ? id_onehot : '0;
  assign resp_valid = (state_reg == ST_RESP) ? id_onehot : '0;

endmodule

// File: doc/fib_arbiter.md
# fib_arbiter

Round-robin arbiter and sequencer that shares one `fib` Fibonacci FSMD between `N_REQ` independent requesters. It accepts level requests carrying a 5-bit index and grants one requester at a time. It drives the `fib` start/index handshake, captures the 20-bit result on `done_tick`, and returns it to the granted requester with a one-cycle response pulse. It sits between the requester-side logic and a single `fib` instance that shares the same `clk`/`rst`.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  N_REQ  level request per requester; held until the matching `resp_valid`.
- `req_i`  in  5*N_REQ  flat index bus; requester k uses bits [5k+4:5k]. Must be stable while `req[k]` is high.
- `grant`  out  N_REQ  one-hot; high for the requester being serviced, from ISSUE (or RESP on a cache hit) through RESP.
- `resp_valid`  out  N_REQ  one-hot, one-cycle pulse; the result is on `resp_f`.
- `resp_f`  out  20  last result; holds its value until the next response.
- `busy`  out  1  high in any state except IDLE.
- `fib_start`  out  1  to `fib.start`; one-cycle pulse.
- `fib_i`  out  5  to `fib.i`; registered index of the granted requester.
- `fib_ready`  in  1  from `fib.ready`.
- `fib_done_tick`  in  1  from `fib.done_tick`.
- `fib_f`  in  20  from `fib.f`.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE**:
  - If any `req` is high and `fib_ready=1`, select the winner by circular search starting at `ptr+1`.
  - Register `id_reg` = winner and `idx_reg` = its `req_i` slice, then go to ISSUE.
  - If no `req` is high, or `fib_ready=0`, stay in IDLE.
- **ISSUE**: drive `fib_start=1` and `fib_i=idx_reg` for exactly one cycle, then go to WAIT.
- **WAIT**:
  - Hold `fib_start=0`.
  - When `fib_done_tick=1`, load `resp_f <= fib_f` and go to RESP.
- **RESP**:
  - Drive `resp_valid[id_reg]=1`.
  - Set `ptr <= id_reg` and go to IDLE.
- Any illegal encoding goes to IDLE.
- `grant` = one-hot of `id_reg` when the state is not IDLE; otherwise 0.
- Results are F(i) modulo 2^20, passed through unchanged:
  - F(0)=0, F(1)=1, F(30)=832040.
  - F(31) wraps to 297693.
  - No overflow flag.
- Requesters deassert `req` on the clock edge at which they sample `resp_valid`. A `req` still high in the following IDLE is treated as a new request.
- Requests that arrive while `busy` wait; there is no queueing beyond the `req` level.
- A request that drops before it is granted is ignored. A request that drops after it is granted is still completed and pulsed.

## Timing
- Reset values:
  - state=IDLE; `ptr`=N_REQ-1, so requester 0 has first priority.
  - `id_reg`, `idx_reg`, `resp_f`, `grant`, `resp_valid`, `busy`, `fib_start`, `fib_i` all 0.
- Latency:
  - Take the arbitration (IDLE) cycle as cycle 0.
  - `fib_start` is high in cycle 1.
  - `resp_valid` is high in cycle 3+max(i,1), i.e. cycle 4 for i∈{0,1} and 12 for i=9.
- Back-to-back: the next grant decision happens in the IDLE cycle immediately after RESP. Minimum spacing between responses is 5 cycles.
- Simultaneous requests: exactly one grant per decision. Under continuous contention, each requester is served within N_REQ decisions.
- Reset mid-operation: outputs return to reset values asynchronously and the in-flight result is discarded. No `resp_valid` is issued for it.
- `fib_done_tick` outside WAIT is ignored.

## Configuration
- Macro `FIB_ARB_CACHE_EN`.
- **Defined**: a single-entry result cache holds `cache_vld`, `cache_idx[4:0]` and `cache_f[19:0]`.
  - `cache_vld` is cleared by reset and written in WAIT on `fib_done_tick`.
  - In IDLE, if the winner's index equals `cache_idx` and `cache_vld=1`, load `resp_f <= cache_f` and go directly to RESP. There is no `fib_start`, and `fib_ready` is not required.
  - Hit latency: `resp_valid` in cycle 1.
- **Undefined**: no cache registers exist, and every request goes through ISSUE/WAIT.

## Test plan
- Reset, then `req[0]` with i=10 → `fib_start` in cycle 1 with `fib_i`=10; `resp_valid`=4'b0001 in cycle 13; `resp_f`=55.
- `req`=4'b1111 with indices 3/5/7/20 held continuously → grants in order 0,1,2,3,0; results 2, 5, 13, 6765.
- i=0, 1, 30, 31 → `resp_f` = 0, 1, 832040, 297693; the first two in cycle 4.
- Assert `rst` while in WAIT with i=25 → all outputs 0 immediately, no `resp_valid`; the next request from requester 0 completes normally.
- With `FIB_ARB_CACHE_EN`: i=20 twice from requester 1 → first response in cycle 23, second in cycle 1 with no `fib_start`, both 6765. Without the macro, both take 23 cycles.
- Hold `fib_ready`=0 with `req[2]` high → stays in IDLE with `busy`=0; grant in the cycle after `fib_ready` rises.
